// File: rtl/bus_port_pkg.sv
// Shared constants, default entry layout and a saturating-increment helper
// used by the bus port router and its FIFO.
package bus_port_pkg;

    localparam int BUS_DATA_W    = 32;
    localparam int BUS_NUM_PORTS = 8;
    localparam int BUS_PORT_W    = $clog2(BUS_NUM_PORTS);

    // Default-width entry; the router re-declares the same layout at its own widths.
    typedef struct packed {
        logic [BUS_PORT_W-1:0] port;
        logic [BUS_DATA_W-1:0] data;
    } bus_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
        logic [31:0] res_s;
        if (value >= max) begin
            res_s = max;
        end else begin
            res_s = value + 32'd1;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/bus_port_fifo.sv
// Generic synchronous FIFO with wrap-around pointers for any DEPTH >= 2.
// Push while full and pop while empty are ignored.
module bus_port_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    import bus_port_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW-1:0]    wptr_next_s;
    logic [AW-1:0]    rptr_next_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign count = count_r;
    assign rdata = mem_r[rptr_r];

    // Qualify requests and compute wrapped pointer successors.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        if (wptr_r == AW'(DEPTH - 1)) begin
            wptr_next_s = '0;
        end else begin
            wptr_next_s = wptr_r + AW'(1);
        end
        if (rptr_r == AW'(DEPTH - 1)) begin
            rptr_next_s = '0;
        end else begin
            rptr_next_s = rptr_r + AW'(1);
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wptr_r] <= wdata;
                wptr_r        <= wptr_next_s;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_next_s;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bus_port_router.sv
// Routes buffered {port, data} transactions in order to one of NUM_PORTS
// output channels and keeps per-port delivery, bad-port and coverage counters.
module bus_port_router
    import bus_port_pkg::*;
#(
    parameter int DATA_W    = BUS_DATA_W,
    parameter int NUM_PORTS = BUS_NUM_PORTS,
    // Derived from NUM_PORTS; leave at its default.
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [PORT_W-1:0]          in_port,
    output logic [NUM_PORTS-1:0]       out_valid,
    input  logic [NUM_PORTS-1:0]       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       clr_counts,
    output logic [NUM_PORTS*CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0]           bad_port_count,
    output logic                       all_hit,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int                CW          = $clog2(DEPTH + 1);
    localparam logic [PORT_W:0]   NUM_PORTS_L = (PORT_W + 1)'(NUM_PORTS);
    localparam logic [31:0]       CNT_MAX     = 32'((64'd1 << CNT_W) - 64'd1);

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                 wr_entry_s;
    entry_t                 head_s;
    logic                   accept_s;
    logic                   port_ok_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   bad_s;
    logic                   full_s;
    logic                   empty_s;
    logic [CW-1:0]          count_s;
    logic [CW-1:0]          count_next_s;
    logic [NUM_PORTS-1:0]   out_valid_s;
    logic                   all_nz_s;
    logic [CNT_W-1:0]       hit_next_s [NUM_PORTS];
    logic [CNT_W-1:0]       bad_next_s;
    logic [CNT_W-1:0]       hit_r [NUM_PORTS];
    logic [CNT_W-1:0]       bad_r;
    logic                   all_hit_r;
    logic                   in_ready_r;
    logic [DATA_W-1:0]      last_data_r;

    bus_port_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wr_entry_s),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Input handshake classification; out-of-range ports are consumed but dropped.
    always_comb begin
        accept_s        = in_valid && in_ready_r;
        port_ok_s       = ({1'b0, in_port} < NUM_PORTS_L);
        push_s          = accept_s && port_ok_s && !full_s;
        bad_s           = accept_s && !port_ok_s;
        wr_entry_s.port = in_port;
        wr_entry_s.data = in_data;
    end

    // One-hot head decode and pop on the head port's handshake.
    always_comb begin
        out_valid_s = '0;
        if (!empty_s) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_valid_s[p] = (head_s.port == PORT_W'(p));
            end
        end else begin
            out_valid_s = '0;
        end
        pop_s = !empty_s && (|(out_valid_s & out_ready));
    end

    // Occupancy after this edge, so in_ready can be registered without an out_ready path.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_s + CW'(1);
            2'b01:   count_next_s = count_s - CW'(1);
            default: count_next_s = count_s;
        endcase
    end

    // Next counter values; clear takes priority over any increment.
    always_comb begin
        all_nz_s = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            all_nz_s = all_nz_s & (|hit_r[p]);
            if (clr_counts) begin
                hit_next_s[p] = '0;
            end else if (pop_s && out_valid_s[p]) begin
                hit_next_s[p] = CNT_W'(sat_inc(32'(hit_r[p]), CNT_MAX));
            end else begin
                hit_next_s[p] = hit_r[p];
            end
        end
        if (clr_counts) begin
            bad_next_s = '0;
        end else if (bad_s) begin
            bad_next_s = CNT_W'(sat_inc(32'(bad_r), CNT_MAX));
        end else begin
            bad_next_s = bad_r;
        end
    end

    // Counter, coverage flag, readiness and last-delivered-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                hit_r[p] <= '0;
            end
            bad_r       <= '0;
            all_hit_r   <= 1'b0;
            in_ready_r  <= 1'b0;
            last_data_r <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                hit_r[p] <= hit_next_s[p];
            end
            bad_r      <= bad_next_s;
            all_hit_r  <= all_nz_s;
            in_ready_r <= (count_next_s < CW'(DEPTH));
            if (pop_s) begin
                last_data_r <= head_s.data;
            end
        end
    end

    // Output mapping; out_data keeps the last delivered value while empty.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            hit_count[p*CNT_W +: CNT_W] = hit_r[p];
        end
        if (empty_s) begin
            out_data = last_data_r;
        end else begin
            out_data = head_s.data;
        end
        out_valid      = out_valid_s;
        in_ready       = in_ready_r;
        bad_port_count = bad_r;
        all_hit        = all_hit_r;
        fifo_count     = count_s;
    end

endmodule

// File: tb/tb_bus_port_router.sv
// Directed bench for bus_port_router: a default 8-port instance and a
// 6-port / 2-bit-counter instance for saturation and bad-port handling.
module tb_bus_port_router;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'd0;
    logic [2:0]   in_port = 3'd0;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready = 8'h00;
    logic [31:0]  out_data;
    logic         clr_counts = 1'b0;
    logic [127:0] hit_count;
    logic [15:0]  bad_port_count;
    logic         all_hit;
    logic [2:0]   fifo_count;

    logic         in_valid_b = 1'b0;
    logic         in_ready_b;
    logic [7:0]   in_data_b = 8'd0;
    logic [2:0]   in_port_b = 3'd0;
    logic [5:0]   out_valid_b;
    logic [5:0]   out_ready_b = 6'h00;
    logic [7:0]   out_data_b;
    logic         clr_counts_b = 1'b0;
    logic [11:0]  hit_count_b;
    logic [1:0]   bad_port_count_b;
    logic         all_hit_b;
    logic [2:0]   fifo_count_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] got [$];
    logic [31:0] exp_order [10] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200,
                                    32'h201, 32'h202, 32'h203, 32'h204, 32'h205};

    always #5 clk = ~clk;

    bus_port_router dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_port(in_port), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .clr_counts(clr_counts),
        .hit_count(hit_count), .bad_port_count(bad_port_count),
        .all_hit(all_hit), .fifo_count(fifo_count)
    );

    bus_port_router #(.DATA_W(8), .NUM_PORTS(6), .DEPTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_port(in_port_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .clr_counts(clr_counts_b),
        .hit_count(hit_count_b), .bad_port_count(bad_port_count_b),
        .all_hit(all_hit_b), .fifo_count(fifo_count_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_fifo_count", 128'(fifo_count), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", 128'(out_data), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_hits", hit_count, 128'd0);
        chk("rst_bad", 128'(bad_port_count), 128'd0);
        chk("rst_all_hit", 128'(all_hit), 128'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Ordering: single transaction to port 3
        out_ready = 8'hFF;
        in_valid = 1'b1; in_port = 3'd3; in_data = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 128'(out_valid), 128'h08);
        chk("t1_out_data", 128'(out_data), 128'hDEAD_BEEF);
        chk("t1_count", 128'(fifo_count), 128'd1);
        step();
        chk("t1_hits", hit_count, 128'h1 << 48);
        chk("t1_empty_valid", 128'(out_valid), 128'd0);
        chk("t1_hold_data", 128'(out_data), 128'hDEAD_BEEF);

        // Full and wrap
        out_ready = 8'h00;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_port = 3'(i); in_data = 32'h100 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        chk("full_count", 128'(fifo_count), 128'd4);
        chk("full_in_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b1; in_port = 3'd0; in_data = 32'hBAD;
        step();
        in_valid = 1'b0;
        chk("full_no_accept", 128'(fifo_count), 128'd4);
        chk("full_head", 128'(out_data), 128'h100);
        out_ready = 8'h0F;
        begin
            int sent;
            logic acc;
            sent = 0;
            for (int c = 0; c < 40; c++) begin
                in_valid = (sent < 6);
                in_port  = 3'(sent % 4);
                in_data  = 32'h200 + 32'(sent);
                acc = in_valid && in_ready;
                if (|(out_valid & out_ready)) got.push_back(out_data);
                step();
                if (acc) sent++;
            end
            in_valid = 1'b0;
        end
        chk("wrap_n_out", 128'(got.size()), 128'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wrap_order_%0d", i), 128'(got[i]), 128'(exp_order[i]));
        end
        chk("wrap_drained", 128'(fifo_count), 128'd0);
        chk("wrap_hits", 128'(hit_count[63:0]), 128'h0003_0002_0003_0003);

        // Head-of-line blocking
        out_ready = 8'h02;
        in_valid = 1'b1; in_port = 3'd5; in_data = 32'h55;
        step();
        in_port = 3'd1; in_data = 32'h11;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("hol_valid", 128'(out_valid), 128'h20);
        chk("hol_count", 128'(fifo_count), 128'd2);
        chk("hol_p1_blocked", 128'(hit_count[31:16]), 128'd3);
        out_ready = 8'h22;
        step();
        chk("hol_p5_hit", 128'(hit_count[95:80]), 128'd1);
        chk("hol_next_valid", 128'(out_valid), 128'h02);
        chk("hol_next_data", 128'(out_data), 128'h11);
        step();
        chk("hol_p1_hit", 128'(hit_count[31:16]), 128'd4);
        chk("hol_empty", 128'(fifo_count), 128'd0);

        // Coverage and clear
        out_ready = 8'hFF;
        chk("cov_not_all", 128'(all_hit), 128'd0);
        for (int p = 0; p < 8; p++) begin
            in_valid = 1'b1; in_port = 3'(p); in_data = 32'h300 + 32'(p);
            step();
        end
        in_valid = 1'b0;
        chk("cov_head_p7", 128'(out_valid), 128'h80);
        chk("cov_pre_all", 128'(all_hit), 128'd0);
        step();
        chk("cov_hits", hit_count, 128'h0001_0001_0002_0001_0004_0003_0005_0004);
        chk("cov_all_lag", 128'(all_hit), 128'd0);
        step();
        chk("cov_all_hit", 128'(all_hit), 128'd1);
        in_valid = 1'b1; in_port = 3'd2; in_data = 32'h322;
        step();
        in_valid = 1'b0;
        chk("clr_head_p2", 128'(out_valid), 128'h04);
        clr_counts = 1'b1;
        step();
        clr_counts = 1'b0;
        chk("clr_hits", hit_count, 128'd0);
        chk("clr_bad", 128'(bad_port_count), 128'd0);
        chk("clr_fifo_popped", 128'(fifo_count), 128'd0);
        step();
        chk("clr_all_hit", 128'(all_hit), 128'd0);

        // Reset mid-operation
        out_ready = 8'h01;
        for (int p = 0; p < 4; p++) begin
            in_valid = 1'b1; in_port = 3'(p); in_data = 32'h400 + 32'(p);
            step();
        end
        in_valid = 1'b0;
        chk("mid_count", 128'(fifo_count), 128'd3);
        chk("mid_hits", hit_count, 128'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_hits", hit_count, 128'd0);
        chk("mid_rst_count", 128'(fifo_count), 128'd0);
        step();
        rst = 1'b0;
        step();
        chk("mid_rel_ready", 128'(in_ready), 128'd1);
        chk("mid_rel_count", 128'(fifo_count), 128'd0);
        chk("mid_rel_valid", 128'(out_valid), 128'd0);
        out_ready = 8'h00;

        // Saturation and bad port on the 6-port, 2-bit-counter instance
        out_ready_b = 6'h3F;
        for (int i = 0; i < 5; i++) begin
            in_valid_b = 1'b1; in_port_b = 3'd4; in_data_b = 8'(i);
            step();
        end
        in_valid_b = 1'b0;
        step();
        chk("sat_hit4", 128'(hit_count_b), 128'h300);
        chk("bad_ready", 128'(in_ready_b), 128'd1);
        in_valid_b = 1'b1; in_port_b = 3'd7; in_data_b = 8'hEE;
        step();
        in_valid_b = 1'b0;
        chk("bad_count1", 128'(bad_port_count_b), 128'd1);
        chk("bad_no_valid", 128'(out_valid_b), 128'd0);
        chk("bad_no_entry", 128'(fifo_count_b), 128'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid_b = 1'b1; in_port_b = 3'd6; in_data_b = 8'hE0;
            step();
        end
        in_valid_b = 1'b0;
        step();
        chk("bad_sat", 128'(bad_port_count_b), 128'd3);
        chk("bad_still_no_valid", 128'(out_valid_b), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
